// File: rtl/ringdefs.sv
// Shared ring word layout: field positions derived from WIDTH/ABITS and slot-type
// decoding. Used by both the SPI-attached node and the parallel-client port.
package ringdefs;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'b00,
      SLOT_ACK     = 2'b01,
      SLOT_PAYLOAD = 2'b10
   } slot_e;

   localparam logic [1:0] ENC_FREE    = 2'b00;
   localparam logic [1:0] ENC_ACK     = 2'b01;
   localparam logic [1:0] ENC_PAYLOAD = 2'b10;

   function automatic int full_pos(input int width);
      return width - 1;
   endfunction

   function automatic int ack_pos(input int width);
      return width - 2;
   endfunction

   function automatic int dst_lsb(input int width, input int abits);
      return width - 2 - abits;
   endfunction

   function automatic int src_lsb(input int width, input int abits);
      return width - 2 - 2 * abits;
   endfunction

   // FULL dominates: any word with FULL set is a payload regardless of ACK.
   function automatic slot_e slot_type(input logic full, input logic ack);
      if (full)
         return SLOT_PAYLOAD;
      else if (ack)
         return SLOT_ACK;
      else
         return SLOT_FREE;
   endfunction

endpackage

// File: rtl/ringfifo.sv
// Synchronous FIFO with registered occupancy count; head word is presented
// combinationally and reads as zero while empty.
module ringfifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ringport.sv
// Parallel-client spinet ring node: one-cycle ring pass-through with slot claim,
// receive/ack rewrite and ack release, decoupled from the client by tx/rx FIFOs.
module ringport
   import ringdefs::*;
#(
   parameter int WIDTH   = 16,
   parameter int ABITS   = 3,
   parameter int ADDRESS = 0,
   parameter int DEPTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] fromring,
   output logic [WIDTH-1:0] toring,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready
);

   localparam int FULL_B = full_pos(WIDTH);
   localparam int ACK_B  = ack_pos(WIDTH);
   localparam int DST_L  = dst_lsb(WIDTH, ABITS);
   localparam int SRC_L  = src_lsb(WIDTH, ABITS);
   localparam logic [ABITS-1:0] MY_ADDR = ABITS'(ADDRESS);

   logic [WIDTH-1:0] tx_head;
   logic             tx_full;
   logic             tx_empty;
   logic             tx_pop;
   logic             rx_full;
   logic             rx_empty;
   logic             rx_push;
   logic             busy;
   logic             claim;
   logic             release_slot;
   logic [WIDTH-1:0] next_word;
   slot_e            slot;

   assign tx_ready = !tx_full;
   assign rx_valid = !rx_empty;

   ringfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid),
      .wdata (tx_data),
      .pop   (tx_pop),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   ringfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .wdata (fromring),
      .pop   (rx_ready),
      .rdata (rx_data),
      .full  (rx_full),
      .empty (rx_empty)
   );

   assign slot = slot_type(fromring[FULL_B], fromring[ACK_B]);

   // Slot decode/rewrite; rx_full is the registered flag, so a same-cycle
   // client pop never lets a full rx FIFO accept.
   always_comb begin
      next_word    = fromring;
      tx_pop       = 1'b0;
      rx_push      = 1'b0;
      claim        = 1'b0;
      release_slot = 1'b0;
      case (slot)
         SLOT_FREE: begin
            if (!tx_empty && !busy) begin
               next_word                     = tx_head;
               next_word[FULL_B]             = ENC_PAYLOAD[1];
               next_word[ACK_B]              = ENC_PAYLOAD[0];
               next_word[SRC_L +: ABITS]     = MY_ADDR;
               claim                         = 1'b1;
            end
         end
         SLOT_PAYLOAD: begin
            if (fromring[DST_L +: ABITS] == MY_ADDR && !rx_full) begin
               next_word[FULL_B] = ENC_ACK[1];
               next_word[ACK_B]  = ENC_ACK[0];
               rx_push           = 1'b1;
            end
         end
         SLOT_ACK: begin
            if (fromring[SRC_L +: ABITS] == MY_ADDR) begin
               next_word[FULL_B] = ENC_FREE[1];
               next_word[ACK_B]  = ENC_FREE[0];
               tx_pop            = 1'b1;
               release_slot      = 1'b1;
            end
         end
         default: begin
            next_word = fromring;
         end
      endcase
   end

   // Ring output stage: every word is delayed exactly one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toring <= '0;
         busy   <= 1'b0;
      end else begin
         toring <= next_word;
         if (claim)
            busy <= 1'b1;
         else if (release_slot)
            busy <= 1'b0;
      end
   end

endmodule
